// File: rtl/avmm_pkg.sv
// Shared Avalon-MM definitions for the memory responder slice.
// Provides bus widths, the bus word type and the stall FSM state encoding.
package avmm_pkg;

    localparam int AVMM_DATA_W = 32;
    localparam int AVMM_ADDR_W = 32;

    typedef logic [AVMM_DATA_W-1:0] avmm_word_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

endpackage

// File: rtl/read_delay_line.sv
// Fixed-latency pipeline carrying {valid, data} for accepted reads.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (flushes all stages)
//   in_valid_i       a read was accepted this cycle
//   in_data_i        word sampled at acceptance
//   out_valid_o      registered, high for one cycle LATENCY cycles after acceptance
//   out_data_o       registered, holds its last value while out_valid_o is low
module read_delay_line
    import avmm_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    input  avmm_word_t in_data_i,
    output logic       out_valid_o,
    output avmm_word_t out_data_o
);

    logic       valid_q [LATENCY];
    avmm_word_t data_q  [LATENCY];

    // Shift stages; data only moves with a valid token so the last stage holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM pipelined responder backed by an on-chip word array.
// Reads return in order after READ_LATENCY cycles; stall injection and a
// pending-read limit exercise master-side waitrequest handling.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   slave_waitrequest     request not accepted this cycle
//   slave_address         byte address (word index in bits [IDX_W+1:2])
//   slave_read/_write     request strobes; both together is a protocol error
//   slave_writedata       write data
//   slave_readdata/_valid read response
//   protocol_err          sticky flag, read and write seen together
//   pending               accepted reads not yet returned
module avmm_mem_responder
    import avmm_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4,
    parameter int STALL_PERIOD = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             slave_waitrequest,
    input  logic [AVMM_ADDR_W-1:0]           slave_address,
    input  logic                             slave_read,
    output avmm_word_t                       slave_readdata,
    output logic                             slave_readdatavalid,
    input  logic                             slave_write,
    input  avmm_word_t                       slave_writedata,
    output logic                             protocol_err,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    // Periods below 2 cannot fit a RUN cycle plus a STALL cycle, so they disable injection.
    localparam bit STALL_EN   = (STALL_PERIOD >= 2);
    localparam int CNT_W      = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
    localparam int CNT_LAST_I = STALL_EN ? (STALL_PERIOD - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

    avmm_word_t         mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]   idx_s;
    logic               unused_addr_s;

    stall_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stall_s;

    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               err_q;

    logic               wait_s;
    logic               rd_acc_s;
    logic               wr_acc_s;
    logic               both_acc_s;
    logic               rdv_s;

    // Upper address bits alias and the byte lane bits are ignored.
    assign idx_s         = slave_address[IDX_W+1:2];
    assign unused_addr_s = ^{slave_address[AVMM_ADDR_W-1:IDX_W+2], slave_address[1:0]};

    assign wait_s     = !rst_n || stall_s || (slave_read && (pend_q == PEND_MAX));
    assign wr_acc_s   = slave_write && !wait_s;
    // A read colliding with a write is dropped: no response, no pending change.
    assign rd_acc_s   = slave_read && !slave_write && !wait_s;
    assign both_acc_s = slave_read && slave_write && !wait_s;

    // Word array; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[idx_s] <= slave_writedata;
        end
    end

    // Stall FSM state and RUN-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall FSM next state: the counter would reach STALL_PERIOD-1 on the last RUN cycle, so hand over to STALL instead.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (STALL_EN && (cnt_q == CNT_LAST)) begin
                    state_d = ST_STALL;
                    cnt_d   = '0;
                end else if (STALL_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_STALL: begin
                stall_s = 1'b1;
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending read counter next state.
    always_comb begin
        pend_d = pend_q;
        case ({rd_acc_s, rdv_s})
            2'b10:   pend_d = pend_q + PEND_W'(1);
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: pend_d = pend_q;
        endcase
    end

    // Pending counter and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_q || both_acc_s;
        end
    end

    read_delay_line #(
        .LATENCY (READ_LATENCY)
    ) u_rdl (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rd_acc_s),
        .in_data_i   (mem_q[idx_s]),
        .out_valid_o (rdv_s),
        .out_data_o  (slave_readdata)
    );

    assign slave_readdatavalid = rdv_s;
    assign slave_waitrequest   = wait_s;
    assign protocol_err        = err_q;
    assign pending             = pend_q;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Scoreboard bench for avmm_mem_responder.
// Instance A: READ_LATENCY=3, MAX_PENDING=2, no stalls.
// Instance B: READ_LATENCY=3, MAX_PENDING=4, STALL_PERIOD=4.
module tb_avmm_mem_responder;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic        a_read = 1'b0, a_write = 1'b0;
    logic [31:0] a_addr = 32'h0, a_wdata = 32'h0;
    logic        a_wait, a_rdv, a_perr;
    logic [31:0] a_rdata;
    logic [1:0]  a_pend;

    // Instance B signals
    logic        b_read = 1'b0, b_write = 1'b0;
    logic [31:0] b_addr = 32'h0, b_wdata = 32'h0;
    logic        b_wait, b_rdv, b_perr;
    logic [31:0] b_rdata;
    logic [2:0]  b_pend;

    avmm_mem_responder #(
        .DEPTH_WORDS(1024), .READ_LATENCY(LAT), .MAX_PENDING(2), .STALL_PERIOD(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(a_wait), .slave_address(a_addr), .slave_read(a_read),
        .slave_readdata(a_rdata), .slave_readdatavalid(a_rdv), .slave_write(a_write),
        .slave_writedata(a_wdata), .protocol_err(a_perr), .pending(a_pend)
    );

    avmm_mem_responder #(
        .DEPTH_WORDS(1024), .READ_LATENCY(LAT), .MAX_PENDING(4), .STALL_PERIOD(4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(b_wait), .slave_address(b_addr), .slave_read(b_read),
        .slave_readdata(b_rdata), .slave_readdatavalid(b_rdv), .slave_write(b_write),
        .slave_writedata(b_wdata), .protocol_err(b_perr), .pending(b_pend)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Pending-limit observation flags for instance A
    bit pend_test_on = 1'b0;
    bit saw_full     = 1'b0;
    bit bad_wait     = 1'b0;
    int max_pend     = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor A: pop expected response on every valid, check data and arrival cycle.
    always @(negedge clk) begin
        if (rst_n && a_rdv) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_valid: got valid with data %h, expected none", a_rdata);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check32("a_rdata", a_rdata, e.data);
                check32("a_latency", cyc, e.due);
            end
        end
        if (pend_test_on) begin
            if (int'(a_pend) > max_pend) max_pend = int'(a_pend);
            if (a_read && a_wait && a_pend == 2'd2) saw_full = 1'b1;
            if (a_wait && a_pend != 2'd2) bad_wait = 1'b1;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst_n && b_rdv) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_valid: got valid with data %h, expected none", b_rdata);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check32("b_rdata", b_rdata, e.data);
                check32("b_latency", cyc, e.due);
            end
        end
    end

    // One handshaked request; called #1 after a posedge, returns #1 after the accept edge.
    task automatic bus_op(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit push, input logic [31:0] exp_data);
        bit   w;
        exp_t e;
        if (sel) begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = wdata;
        end else begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = wdata;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            w = sel ? b_wait : a_wait;
            if (!w) begin
                if (push) begin
                    e.data = exp_data;
                    e.due  = cyc + LAT;
                    if (sel) qb.push_back(e);
                    else     qa.push_back(e);
                end
                @(posedge clk);
                #1;
                if (sel) begin b_read = 1'b0; b_write = 1'b0; end
                else     begin a_read = 1'b0; a_write = 1'b0; end
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL bus_op_timeout: request at %h never accepted, expected accept within 50 cycles", addr);
        if (sel) begin b_read = 1'b0; b_write = 1'b0; end
        else     begin a_read = 1'b0; a_write = 1'b0; end
    endtask

    task automatic drain(input bit sel);
        for (int i = 0; i < 30; i++) begin
            if ((sel ? qb.size() : qa.size()) == 0) break;
            @(posedge clk);
        end
        #1;
        check32(sel ? "b_drain" : "a_drain", sel ? qb.size() : qa.size(), 32'd0);
    endtask

    initial begin
        int k;
        int waits;
        int last_w;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check32("rst_wait", {31'b0, a_wait}, 32'd1);
        check32("rst_rdv", {31'b0, a_rdv}, 32'd0);
        check32("rst_rdata", a_rdata, 32'h0);
        check32("rst_perr", {31'b0, a_perr}, 32'd0);
        check32("rst_pend", {30'b0, a_pend}, 32'd0);
        check32("rst_wait_b", {31'b0, b_wait}, 32'd1);

        // Write pending at release is accepted on the very first edge
        a_write = 1'b1; a_addr = 32'h10; a_wdata = 32'hCAFEF00D;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check32("first_edge_wait", {31'b0, a_wait}, 32'd0);
        @(posedge clk);
        #1;
        a_write = 1'b0;
        bus_op(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFEF00D);
        drain(1'b0);

        // Address wrap and byte-lane bits ignored
        bus_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 32'h0);
        bus_op(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h1);
        bus_op(1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 32'h1);
        drain(1'b0);

        // Pending limit with MAX_PENDING=2
        for (int i = 0; i < 8; i++)
            bus_op(1'b0, 1'b0, 1'b1, 32'h40 + 32'(4*i), 32'hA5A50000 + 32'(i), 1'b0, 32'h0);
        pend_test_on = 1'b1;
        for (int i = 0; i < 8; i++)
            bus_op(1'b0, 1'b1, 1'b0, 32'h40 + 32'(4*i), 32'h0, 1'b1, 32'hA5A50000 + 32'(i));
        drain(1'b0);
        pend_test_on = 1'b0;
        check32("pend_max_le2", {31'b0, (max_pend <= 2)}, 32'd1);
        check32("pend_wait_seen", {31'b0, saw_full}, 32'd1);
        check32("pend_no_spurious_wait", {31'b0, bad_wait}, 32'd0);

        // Read and write together: write wins, read dropped, error sticks
        bus_op(1'b0, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0, 32'h0);
        @(negedge clk);
        check32("perr_set", {31'b0, a_perr}, 32'd1);
        check32("perr_pend", {30'b0, a_pend}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check32("perr_sticky", {31'b0, a_perr}, 32'd1);
        bus_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h55);
        drain(1'b0);

        // Stall injection on B: 12 cycles of write -> 3 stalls, 9 accepts, 4 apart
        k = 0; waits = 0; last_w = -1;
        b_write = 1'b1;
        for (int j = 0; j < 12; j++) begin
            b_addr  = 32'h100 + 32'(4*k);
            b_wdata = 32'hB0000000 + 32'(k);
            @(negedge clk);
            if (b_wait) begin
                waits++;
                if (last_w >= 0) check32("stall_gap", 32'(j - last_w), 32'd4);
                last_w = j;
            end else begin
                k++;
            end
            @(posedge clk);
            #1;
        end
        b_write = 1'b0;
        check32("stall_accepts", 32'(k), 32'd9);
        check32("stall_waits", 32'(waits), 32'd3);
        for (int i = 0; i < 9; i++)
            bus_op(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4*i), 32'h0, 1'b1, 32'hB0000000 + 32'(i));
        drain(1'b1);

        // Reset one cycle after two accepted reads: no response may follow
        bus_op(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hA5A50000);
        bus_op(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'hA5A50001);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check32("rst_mid_pend", {30'b0, a_pend}, 32'd0);
        check32("rst_mid_perr", {31'b0, a_perr}, 32'd0);
        check32("rst_mid_rdv", {31'b0, a_rdv}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check32("rst_mid_pend_after", {30'b0, a_pend}, 32'd0);

        check32("final_qa_empty", qa.size(), 32'd0);
        check32("final_qb_empty", qb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
